// File: rtl/mpmc11_resp_burst_tracker.sv
// Purpose : tracks up to DEPTH outstanding read bursts (channel + length) and tags returning response beats.
// Latency : 1 cycle from resp_valid to the registered beat_valid/beat_chan/beat_cnt/beat_last.
// Backpressure: cmd_ready drops when the burst FIFO is full or during flush; responses are never stalled.
//
// Ports:
//   clk, rstn             clock, synchronous active-low reset
//   flush                 abort all outstanding bursts (discards same-cycle cmd/resp)
//   cmd_valid/cmd_ready   burst issue handshake; cmd_chan owns it, cmd_len = beats-1
//   resp_valid            one response beat returned from memory
//   beat_valid/chan/cnt/last  registered per-beat tag of the matched beat
//   busy, count           FIFO occupancy status
//   err_unexp             sticky flag: a beat arrived with nothing outstanding
module mpmc11_resp_burst_tracker #(
    parameter int CHANNELS = 8,
    parameter int LENW     = 6,
    parameter int DEPTH    = 4,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PW      = $clog2(DEPTH),
    localparam int CNTW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [CW-1:0]   cmd_chan,
    input  logic [LENW-1:0] cmd_len,
    input  logic            resp_valid,
    output logic            beat_valid,
    output logic [CW-1:0]   beat_chan,
    output logic [LENW-1:0] beat_cnt,
    output logic            beat_last,
    output logic            busy,
    output logic [CNTW-1:0] count,
    output logic            err_unexp
);

    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    // Burst FIFO storage (no reset needed: only read when count != 0)
    logic [CW-1:0]   chan_mem_q [DEPTH];
    logic [LENW-1:0] len_mem_q  [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [LENW-1:0] cnt_q, cnt_d;

    logic            beat_valid_q, beat_valid_d;
    logic [CW-1:0]   beat_chan_q, beat_chan_d;
    logic [LENW-1:0] beat_cnt_q, beat_cnt_d;
    logic            beat_last_q, beat_last_d;
    logic            err_q, err_d;

    logic            full;
    logic            push;
    logic            match;
    logic            pop;
    logic            is_last;
    logic [CW-1:0]   head_chan;
    logic [LENW-1:0] head_len;

    assign full      = (count_q == FULL_CNT);
    assign busy      = (count_q != '0);
    assign cmd_ready = !full && !flush;

    assign head_chan = chan_mem_q[rd_ptr_q];
    assign head_len  = len_mem_q[rd_ptr_q];
    assign is_last   = (cnt_q == head_len);

    // cmd_ready already excludes flush, so a flushed push is dropped here.
    assign push  = cmd_valid && cmd_ready;
    // busy is pre-push occupancy: a beat can never match a burst pushed this cycle.
    assign match = resp_valid && busy && !flush;
    assign pop   = match && is_last;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        cnt_d        = cnt_q;
        beat_valid_d = 1'b0;
        beat_chan_d  = beat_chan_q;
        beat_cnt_d   = beat_cnt_q;
        beat_last_d  = beat_last_q;
        err_d        = err_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase

            if (match) begin
                beat_valid_d = 1'b1;
                beat_chan_d  = head_chan;
                beat_cnt_d   = cnt_q;
                beat_last_d  = is_last;
                // cnt stops at head_len, so it can never wrap even for the max length.
                cnt_d        = is_last ? '0 : cnt_q + LENW'(1);
            end else if (resp_valid) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            chan_mem_q[wr_ptr_q] <= cmd_chan;
            len_mem_q[wr_ptr_q]  <= cmd_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cnt_q        <= '0;
            beat_valid_q <= 1'b0;
            beat_chan_q  <= '0;
            beat_cnt_q   <= '0;
            beat_last_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cnt_q        <= cnt_d;
            beat_valid_q <= beat_valid_d;
            beat_chan_q  <= beat_chan_d;
            beat_cnt_q   <= beat_cnt_d;
            beat_last_q  <= beat_last_d;
            err_q        <= err_d;
        end
    end

    assign beat_valid = beat_valid_q;
    assign beat_chan  = beat_chan_q;
    assign beat_cnt   = beat_cnt_q;
    assign beat_last  = beat_last_q;
    assign count      = count_q;
    assign err_unexp  = err_q;

endmodule
